// File: rtl/lc3b_types.sv
// Shared LC-3b types and the line-memory responder state encoding.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_mem_data;

    localparam int LC3B_LINE_OFFSET_BITS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } pmem_state_t;

endpackage

// File: rtl/pmem_responder_if.sv
// Cache-to-memory line interface; master is the cache controller, slave the memory.
interface pmem_responder_if;
    import lc3b_types::*;

    logic         pmem_read;
    logic         pmem_write;
    lc3b_word     pmem_address;
    lc3b_mem_data pmem_wdata;
    logic         pmem_resp;
    lc3b_mem_data pmem_rdata;
    logic         pmem_error;

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_resp, pmem_rdata, pmem_error
    );

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_resp, pmem_rdata, pmem_error
    );

endinterface

// File: rtl/pmem_array.sv
// Line storage: combinational read, synchronous write, contents never reset.
module pmem_array
    import lc3b_types::*;
#(
    parameter int DEPTH_LINES = 32,
    parameter int IDX_W       = $clog2(DEPTH_LINES)
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] index,
    input  logic             we,
    input  lc3b_mem_data     wdata,
    output lc3b_mem_data     rdata
);

    lc3b_mem_data mem [DEPTH_LINES];

    assign rdata = mem[index];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[index] <= wdata;
        end
    end

endmodule

// File: rtl/pmem_responder.sv
// Fixed-latency line memory responder at the far end of the cache line interface.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for pmem_read/pmem_write; request captured here
//   BUSY  | latency down-counter running; abort if request is dropped
//   RESP  | one-cycle pmem_resp; a captured write commits on exit
module pmem_responder
    import lc3b_types::*;
#(
    parameter int LATENCY     = 4,
    parameter int DEPTH_LINES = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    pmem_responder_if.slave   bus
);

    localparam int CNT_W = $clog2(LATENCY);
    localparam int IDX_W = $clog2(DEPTH_LINES);

    pmem_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       req_q;
    logic             op_write;
    lc3b_word         addr_q;
    lc3b_mem_data     wdata_q;
    logic             resp_q;
    logic             error_q;
    lc3b_mem_data     rdata_q;

    logic [IDX_W-1:0] index;
    logic             arr_we;
    lc3b_mem_data     arr_rdata;

    assign index  = addr_q[LC3B_LINE_OFFSET_BITS +: IDX_W];
    assign arr_we = (state == RESP) && op_write;

    pmem_array #(
        .DEPTH_LINES (DEPTH_LINES),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .index (index),
        .we    (arr_we),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            req_q    <= '0;
            op_write <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            resp_q   <= 1'b0;
            error_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.pmem_read || bus.pmem_write) begin
                        state    <= BUSY;
                        cnt      <= CNT_W'(LATENCY - 2);
                        req_q    <= {bus.pmem_read, bus.pmem_write};
                        op_write <= bus.pmem_write;
                        addr_q   <= bus.pmem_address;
                        wdata_q  <= bus.pmem_wdata;
                        if (bus.pmem_read && bus.pmem_write) begin
                            error_q <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (!bus.pmem_read && !bus.pmem_write) begin
                        state   <= IDLE;
                        error_q <= 1'b1;
                    end else begin
                        // Captured op/address run to completion even if the initiator wobbles.
                        if (({bus.pmem_read, bus.pmem_write} != req_q) ||
                            (bus.pmem_address != addr_q)) begin
                            error_q <= 1'b1;
                        end
                        if (cnt == '0) begin
                            state  <= RESP;
                            resp_q <= 1'b1;
                            if (!op_write) begin
                                rdata_q <= arr_rdata;
                            end
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    resp_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    resp_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pmem_resp  = resp_q;
    assign bus.pmem_rdata = rdata_q;
    assign bus.pmem_error = error_q;

endmodule

// File: tb/tb_pmem_responder.sv
// Scoreboard bench for pmem_responder: directed accesses queue expected responses, a monitor checks them.
module tb_pmem_responder;
    import lc3b_types::*;

    localparam int LATENCY     = 4;
    localparam int DEPTH_LINES = 32;

    localparam logic [1:0] M_NONE = 2'd0;
    localparam logic [1:0] M_EQ   = 2'd1;
    localparam logic [1:0] M_NEQ  = 2'd2;

    localparam lc3b_mem_data LINE_W1 = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam lc3b_mem_data LINE_A  = 128'hAAAA_1111_2222_3333_4444_5555_6666_AAAA;
    localparam lc3b_mem_data LINE_E  = 128'hE0E0_E1E1_E2E2_E3E3_E4E4_E5E5_E6E6_E7E7;
    localparam lc3b_mem_data LINE_F  = 128'hF00D_F00D_0000_1111_2222_3333_F00D_F00D;
    localparam lc3b_mem_data LINE_G  = 128'h6666_0000_6666_0000_6666_0000_6666_0000;
    localparam lc3b_mem_data LINE_H  = 128'h1234_5678_9ABC_DEF0_1234_5678_9ABC_DEF0;
    localparam lc3b_mem_data LINE_B  = 128'hBBBB_BBBB_0000_0001_BBBB_BBBB_0000_0002;
    localparam lc3b_mem_data LINE_C  = 128'hCCCC_CCCC_0000_0003_CCCC_CCCC_0000_0004;

    typedef struct {
        logic [1:0]   mode;
        lc3b_mem_data data;
        int           cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;
    int   resp_count;
    exp_t sb [$];

    pmem_responder_if bus ();

    pmem_responder #(
        .LATENCY     (LATENCY),
        .DEPTH_LINES (DEPTH_LINES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle_bus();
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = '0;
        bus.pmem_wdata   = '0;
    endtask

    // Drive one access in the current cycle, hold through resp, release in the following idle cycle.
    task automatic do_access(input logic rd, input logic wr, input lc3b_word a,
                             input lc3b_mem_data wd, input logic [1:0] mode,
                             input lc3b_mem_data exp);
        exp_t e;
        bus.pmem_read    = rd;
        bus.pmem_write   = wr;
        bus.pmem_address = a;
        bus.pmem_wdata   = wd;
        e.mode = mode;
        e.data = exp;
        e.cyc  = cyc + LATENCY;
        sb.push_back(e);
        repeat (LATENCY + 1) @(posedge clk);
        #1;
        idle_bus();
    endtask

    task automatic pulse_reset();
        #1;
        rst_n = 1'b0;
        idle_bus();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: every pmem_resp must match the head of the scoreboard.
    initial begin
        exp_t e;
        resp_count = 0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.pmem_resp) begin
                resp_count++;
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 128'(cyc), 128'(-1));
                end else begin
                    e = sb.pop_front();
                    chk("resp_cycle", 128'(cyc), 128'(e.cyc));
                    if (e.mode == M_EQ) begin
                        chk("rdata", bus.pmem_rdata, e.data);
                    end else if (e.mode == M_NEQ) begin
                        chk("rdata_differs", 128'(bus.pmem_rdata != e.data), 128'(1));
                    end
                end
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        idle_bus();

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            bus.pmem_read    = 1'($urandom);
            bus.pmem_write   = 1'($urandom);
            bus.pmem_address = 16'($urandom);
            bus.pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
            #3;
            chk("rst_resp",  128'(bus.pmem_resp), 128'(0));
            chk("rst_rdata", bus.pmem_rdata,      128'(0));
            chk("rst_error", 128'(bus.pmem_error), 128'(0));
        end
        @(posedge clk);
        #1;
        idle_bus();
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_no_resp", 128'(resp_count), 128'(0));

        // Write then read, exact latency
        do_access(1'b0, 1'b1, 16'h0040, LINE_W1, M_NONE, '0);
        do_access(1'b1, 1'b0, 16'h0040, '0, M_EQ, LINE_W1);
        chk("rdata_hold_after_write", bus.pmem_rdata, LINE_W1);

        // Offset bits ignored, high bits alias
        do_access(1'b0, 1'b1, 16'h0045, LINE_A, M_NONE, '0);
        chk("rdata_unchanged_by_write", bus.pmem_rdata, LINE_W1);
        do_access(1'b1, 1'b0, 16'h0040, '0, M_EQ, LINE_A);
        do_access(1'b1, 1'b0, 16'h0240, '0, M_EQ, LINE_A);
        do_access(1'b1, 1'b0, 16'h0050, '0, M_NEQ, LINE_A);

        // Back-to-back reads with request held high
        do_access(1'b0, 1'b1, 16'h0100, LINE_E, M_NONE, '0);
        base = resp_count;
        bus.pmem_read    = 1'b1;
        bus.pmem_address = 16'h0100;
        sb.push_back('{M_EQ, LINE_E, cyc + LATENCY});
        sb.push_back('{M_EQ, LINE_E, cyc + 2 * LATENCY + 1});
        repeat (2 * (LATENCY + 1)) @(posedge clk);
        #1;
        idle_bus();
        chk("b2b_resp_count", 128'(resp_count - base), 128'(2));
        chk("b2b_error", 128'(bus.pmem_error), 128'(0));

        // Read and write together: write wins, error is sticky
        do_access(1'b1, 1'b1, 16'h0300, LINE_F, M_NONE, '0);
        chk("both_error", 128'(bus.pmem_error), 128'(1));
        do_access(1'b1, 1'b0, 16'h0300, '0, M_EQ, LINE_F);
        repeat (3) @(posedge clk);
        #1;
        chk("error_sticky", 128'(bus.pmem_error), 128'(1));

        // Dropped write request during BUSY aborts without committing
        pulse_reset();
        chk("error_cleared", 128'(bus.pmem_error), 128'(0));
        do_access(1'b0, 1'b1, 16'h0140, LINE_G, M_NONE, '0);
        base = resp_count;
        bus.pmem_write   = 1'b1;
        bus.pmem_address = 16'h0140;
        bus.pmem_wdata   = LINE_H;
        repeat (2) @(posedge clk);
        #1;
        idle_bus();
        repeat (LATENCY + 2) @(posedge clk);
        #1;
        chk("abort_no_resp", 128'(resp_count - base), 128'(0));
        chk("abort_error", 128'(bus.pmem_error), 128'(1));
        do_access(1'b1, 1'b0, 16'h0140, '0, M_EQ, LINE_G);

        // Reset in the middle of a write discards it
        pulse_reset();
        do_access(1'b0, 1'b1, 16'h0080, LINE_B, M_NONE, '0);
        base = resp_count;
        bus.pmem_write   = 1'b1;
        bus.pmem_address = 16'h0080;
        bus.pmem_wdata   = LINE_C;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        idle_bus();
        #1;
        chk("midrst_resp", 128'(bus.pmem_resp), 128'(0));
        chk("midrst_state", 128'(dut.state), 128'(IDLE));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (LATENCY) @(posedge clk);
        #1;
        chk("midrst_no_resp", 128'(resp_count - base), 128'(0));
        do_access(1'b1, 1'b0, 16'h0080, '0, M_EQ, LINE_B);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 128'(sb.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
